// File: rtl/opcode_extractor.sv
// ---------------------------------------------------------------------------
// opcode_extractor
//
// Purpose:
//   Front of the decode stage. Consumes the raw x86 instruction byte stream
//   from the fetch byte queue one byte per cycle, strips and records legacy
//   prefixes, folds the 0F escape into a 16-bit opcode and presents the
//   opcode plus prefix state to decode (ModRM detector, length decoder)
//   under a valid/ready handshake that holds the bundle until consumed.
//
// Parameters:
//   MAX_PREFIX   prefix bytes allowed before pfx_err is raised (1..14)
//
// Ports:
//   clk          in   1   clock, all state on rising edge
//   rst_n        in   1   asynchronous active-low reset
//   flush        in   1   synchronous abandon of the current instruction
//   in_valid     in   1   in_byte is valid
//   in_byte      in   8   next instruction byte
//   in_ready     out  1   byte accepted when in_valid & in_ready
//   out_valid    out  1   opcode/prefix bundle valid and held
//   out_ready    in   1   decode consumes bundle when out_valid & out_ready
//   opcode       out  16  {8'h0F or 8'h00, opcode byte}
//   pfx_opsize   out  1   66 operand-size prefix seen
//   pfx_lock     out  1   F0 lock prefix seen
//   pfx_rep      out  1   F3 is the active rep prefix
//   pfx_repne    out  1   F2 is the active rep prefix
//   seg_ovr_vld  out  1   segment override present
//   seg_ovr      out  3   ES=0 CS=1 SS=2 DS=3 FS=4 GS=5
//   pfx_count    out  4   prefix bytes consumed, saturating at 15
//   pfx_err      out  1   pfx_count exceeded MAX_PREFIX
// ---------------------------------------------------------------------------
module opcode_extractor #(
    parameter int MAX_PREFIX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] opcode,
    output logic        pfx_opsize,
    output logic        pfx_lock,
    output logic        pfx_rep,
    output logic        pfx_repne,
    output logic        seg_ovr_vld,
    output logic [2:0]  seg_ovr,
    output logic [3:0]  pfx_count,
    output logic        pfx_err
);

    typedef enum logic [1:0] {
        ST_PFX  = 2'd0,
        ST_ESC  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [7:0] ESCAPE_BYTE = 8'h0F;
    localparam logic [3:0] MAX_PFX_L   = 4'(MAX_PREFIX);
    localparam logic [3:0] COUNT_SAT   = 4'hF;

    state_t      state;

    logic        byte_take;
    logic        is_seg;
    logic [2:0]  seg_code;
    logic        is_opsize;
    logic        is_lock;
    logic        is_rep;
    logic        is_repne;
    logic        is_prefix;
    logic        is_escape;
    logic [3:0]  count_inc;

    // The queue may only hand us a byte while we are still collecting; a
    // flush in the same cycle means whatever is on in_byte belongs to the
    // abandoned path, so it must not be taken.
    assign in_ready  = (state != ST_HOLD) && !flush;
    assign byte_take = in_valid && in_ready;

    // Classify the incoming byte as a legacy prefix. Segment overrides map
    // onto the architectural segment register number so decode can use
    // seg_ovr directly as a register index.
    always_comb begin
        is_seg    = 1'b0;
        seg_code  = 3'd0;
        is_opsize = 1'b0;
        is_lock   = 1'b0;
        is_rep    = 1'b0;
        is_repne  = 1'b0;
        unique case (in_byte)
            8'h26:   begin is_seg = 1'b1; seg_code = 3'd0; end
            8'h2E:   begin is_seg = 1'b1; seg_code = 3'd1; end
            8'h36:   begin is_seg = 1'b1; seg_code = 3'd2; end
            8'h3E:   begin is_seg = 1'b1; seg_code = 3'd3; end
            8'h64:   begin is_seg = 1'b1; seg_code = 3'd4; end
            8'h65:   begin is_seg = 1'b1; seg_code = 3'd5; end
            8'h66:   is_opsize = 1'b1;
            8'hF0:   is_lock   = 1'b1;
            8'hF3:   is_rep    = 1'b1;
            8'hF2:   is_repne  = 1'b1;
            default: ;
        endcase
    end

    assign is_prefix = is_seg || is_opsize || is_lock || is_rep || is_repne;
    assign is_escape = (in_byte == ESCAPE_BYTE);

    // Prefix counter saturates so long runs of redundant prefixes cannot
    // wrap back under the error threshold.
    assign count_inc = (pfx_count == COUNT_SAT) ? COUNT_SAT : (pfx_count + 4'd1);

    // Main sequencer. Outputs are all registered; prefix flags become
    // visible as they accumulate, but decode only trusts them with
    // out_valid. The opcode register is left untouched by flush and by
    // consumption since nobody looks at it without out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_PFX;
            out_valid   <= 1'b0;
            opcode      <= 16'h0000;
            pfx_opsize  <= 1'b0;
            pfx_lock    <= 1'b0;
            pfx_rep     <= 1'b0;
            pfx_repne   <= 1'b0;
            seg_ovr_vld <= 1'b0;
            seg_ovr     <= 3'd0;
            pfx_count   <= 4'd0;
            pfx_err     <= 1'b0;
        end else if (flush) begin
            state       <= ST_PFX;
            out_valid   <= 1'b0;
            pfx_opsize  <= 1'b0;
            pfx_lock    <= 1'b0;
            pfx_rep     <= 1'b0;
            pfx_repne   <= 1'b0;
            seg_ovr_vld <= 1'b0;
            seg_ovr     <= 3'd0;
            pfx_count   <= 4'd0;
            pfx_err     <= 1'b0;
        end else begin
            case (state)
                ST_PFX: begin
                    if (byte_take) begin
                        if (is_prefix) begin
                            // Duplicates are counted every time; an excess
                            // only marks the bundle bad, it never stalls.
                            pfx_count <= count_inc;
                            if (count_inc > MAX_PFX_L) begin
                                pfx_err <= 1'b1;
                            end
                            if (is_seg) begin
                                seg_ovr_vld <= 1'b1;
                                seg_ovr     <= seg_code;
                            end
                            if (is_opsize) begin
                                pfx_opsize <= 1'b1;
                            end
                            if (is_lock) begin
                                pfx_lock <= 1'b1;
                            end
                            // F2/F3 are mutually exclusive; last one wins.
                            if (is_rep) begin
                                pfx_rep   <= 1'b1;
                                pfx_repne <= 1'b0;
                            end
                            if (is_repne) begin
                                pfx_repne <= 1'b1;
                                pfx_rep   <= 1'b0;
                            end
                        end else if (is_escape) begin
                            state <= ST_ESC;
                        end else begin
                            opcode    <= {8'h00, in_byte};
                            out_valid <= 1'b1;
                            state     <= ST_HOLD;
                        end
                    end
                end

                // After 0F every byte is the second opcode byte, even if it
                // looks like a prefix.
                ST_ESC: begin
                    if (byte_take) begin
                        opcode    <= {ESCAPE_BYTE, in_byte};
                        out_valid <= 1'b1;
                        state     <= ST_HOLD;
                    end
                end

                // Bundle is frozen until decode takes it. The consume cycle
                // is a bubble: in_ready is low throughout HOLD.
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid   <= 1'b0;
                        pfx_opsize  <= 1'b0;
                        pfx_lock    <= 1'b0;
                        pfx_rep     <= 1'b0;
                        pfx_repne   <= 1'b0;
                        seg_ovr_vld <= 1'b0;
                        seg_ovr     <= 3'd0;
                        pfx_count   <= 4'd0;
                        pfx_err     <= 1'b0;
                        state       <= ST_PFX;
                    end
                end

                default: begin
                    state     <= ST_PFX;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_opcode_extractor.sv
// ---------------------------------------------------------------------------
// tb_opcode_extractor
//
// Directed self-checking bench for opcode_extractor with MAX_PREFIX=4.
// Inputs are driven 1ns after the rising edge; outputs are sampled 1ns after
// the edge that follows, and in_ready is sampled just before that edge.
// ---------------------------------------------------------------------------
module tb_opcode_extractor;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] opcode;
    logic        pfx_opsize;
    logic        pfx_lock;
    logic        pfx_rep;
    logic        pfx_repne;
    logic        seg_ovr_vld;
    logic [2:0]  seg_ovr;
    logic [3:0]  pfx_count;
    logic        pfx_err;

    int          checkCount;
    int          failCount;
    logic        lastInReady;

    opcode_extractor #(
        .MAX_PREFIX(4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_byte     (in_byte),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .opcode      (opcode),
        .pfx_opsize  (pfx_opsize),
        .pfx_lock    (pfx_lock),
        .pfx_rep     (pfx_rep),
        .pfx_repne   (pfx_repne),
        .seg_ovr_vld (seg_ovr_vld),
        .seg_ovr     (seg_ovr),
        .pfx_count   (pfx_count),
        .pfx_err     (pfx_err)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [15:0] actual,
                               input logic [15:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of byte stream, capture in_ready just before the edge,
    // then step to 1ns after the edge.
    task automatic applyStimulus(input logic valid, input logic [7:0] data);
        in_valid = valid;
        in_byte  = data;
        #1;
        lastInReady = in_ready;
        @(posedge clk);
        #1;
    endtask

    // Hand one held bundle to decode with nothing arriving on the byte side.
    task automatic consumeBundle();
        out_ready = 1'b1;
        applyStimulus(1'b0, 8'h00);
        out_ready = 1'b0;
    endtask

    initial begin
        checkCount  = 0;
        failCount   = 0;
        lastInReady = 1'b0;
        rst_n       = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_byte     = 8'h00;
        out_ready   = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 16'(out_valid), 16'h0);
        checkOutput("rst_opcode", opcode, 16'h0000);
        checkOutput("rst_count", 16'(pfx_count), 16'h0);
        checkOutput("rst_err", 16'(pfx_err), 16'h0);
        checkOutput("rst_in_ready", 16'(in_ready), 16'h1);
        rst_n = 1'b1;

        // Plain one-byte opcode: valid right after the accepting edge
        applyStimulus(1'b1, 8'h05);
        checkOutput("t1_out_valid", 16'(out_valid), 16'h1);
        checkOutput("t1_opcode", opcode, 16'h0005);
        checkOutput("t1_count", 16'(pfx_count), 16'h0);
        checkOutput("t1_in_ready", 16'(in_ready), 16'h0);
        consumeBundle();
        checkOutput("t1_consumed", 16'(out_valid), 16'h0);
        checkOutput("t1_back_ready", 16'(in_ready), 16'h1);

        // 66 F3 0F AF with decode always ready
        out_ready = 1'b1;
        applyStimulus(1'b1, 8'h66);
        checkOutput("t2_opsize_early", 16'(pfx_opsize), 16'h1);
        checkOutput("t2_count_early", 16'(pfx_count), 16'h1);
        applyStimulus(1'b1, 8'hF3);
        applyStimulus(1'b1, 8'h0F);
        checkOutput("t2_esc_no_valid", 16'(out_valid), 16'h0);
        checkOutput("t2_esc_count", 16'(pfx_count), 16'h2);
        applyStimulus(1'b1, 8'hAF);
        checkOutput("t2_out_valid", 16'(out_valid), 16'h1);
        checkOutput("t2_opcode", opcode, 16'h0FAF);
        checkOutput("t2_opsize", 16'(pfx_opsize), 16'h1);
        checkOutput("t2_rep", 16'(pfx_rep), 16'h1);
        checkOutput("t2_count", 16'(pfx_count), 16'h2);
        // Consume cycle is a bubble: offered byte 05 must be ignored
        applyStimulus(1'b1, 8'h05);
        checkOutput("t2_bubble_ready", 16'(lastInReady), 16'h0);
        checkOutput("t2_released", 16'(out_valid), 16'h0);
        checkOutput("t2_count_clr", 16'(pfx_count), 16'h0);
        checkOutput("t2_opsize_clr", 16'(pfx_opsize), 16'h0);
        checkOutput("t2_rep_clr", 16'(pfx_rep), 16'h0);
        applyStimulus(1'b0, 8'h00);
        checkOutput("t2_byte_dropped", 16'(out_valid), 16'h0);
        out_ready = 1'b0;

        // F2 F3 2E 3E 89: last rep/segment wins, count at the limit
        applyStimulus(1'b1, 8'hF2);
        checkOutput("t3_repne_early", 16'(pfx_repne), 16'h1);
        applyStimulus(1'b1, 8'hF3);
        applyStimulus(1'b1, 8'h2E);
        checkOutput("t3_seg_early", 16'(seg_ovr), 16'h1);
        applyStimulus(1'b1, 8'h3E);
        applyStimulus(1'b1, 8'h89);
        checkOutput("t3_out_valid", 16'(out_valid), 16'h1);
        checkOutput("t3_opcode", opcode, 16'h0089);
        checkOutput("t3_rep", 16'(pfx_rep), 16'h1);
        checkOutput("t3_repne", 16'(pfx_repne), 16'h0);
        checkOutput("t3_seg_vld", 16'(seg_ovr_vld), 16'h1);
        checkOutput("t3_seg", 16'(seg_ovr), 16'h3);
        checkOutput("t3_count", 16'(pfx_count), 16'h4);
        checkOutput("t3_err", 16'(pfx_err), 16'h0);
        checkOutput("t3_lock", 16'(pfx_lock), 16'h0);
        consumeBundle();

        // Five 66 then 90: error once count passes 4, bundle still completes
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 8'h66);
            if (i == 3) begin
                checkOutput("t4_err_at_limit", 16'(pfx_err), 16'h0);
            end
        end
        checkOutput("t4_err_over", 16'(pfx_err), 16'h1);
        applyStimulus(1'b1, 8'h90);
        checkOutput("t4_out_valid", 16'(out_valid), 16'h1);
        checkOutput("t4_opcode", opcode, 16'h0090);
        checkOutput("t4_count", 16'(pfx_count), 16'h5);
        checkOutput("t4_err", 16'(pfx_err), 16'h1);
        consumeBundle();
        checkOutput("t4_err_clr", 16'(pfx_err), 16'h0);

        // 0F 01 held for three cycles with bytes pushing behind it
        applyStimulus(1'b1, 8'h0F);
        applyStimulus(1'b1, 8'h01);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'h8B);
            checkOutput("t5_in_ready", 16'(lastInReady), 16'h0);
            checkOutput("t5_hold_valid", 16'(out_valid), 16'h1);
            checkOutput("t5_hold_opcode", opcode, 16'h0F01);
        end
        consumeBundle();
        checkOutput("t5_freed", 16'(out_valid), 16'h0);

        // 66 0F then flush with a byte offered: byte dropped, escape lost
        applyStimulus(1'b1, 8'h66);
        applyStimulus(1'b1, 8'h0F);
        flush = 1'b1;
        applyStimulus(1'b1, 8'h55);
        flush = 1'b0;
        checkOutput("t6_flush_ready", 16'(lastInReady), 16'h0);
        checkOutput("t6_flush_valid", 16'(out_valid), 16'h0);
        checkOutput("t6_flush_opsize", 16'(pfx_opsize), 16'h0);
        checkOutput("t6_flush_count", 16'(pfx_count), 16'h0);
        checkOutput("t6_flush_opcode", opcode, 16'h0F01);
        applyStimulus(1'b1, 8'h8B);
        checkOutput("t6_out_valid", 16'(out_valid), 16'h1);
        checkOutput("t6_opcode", opcode, 16'h008B);
        checkOutput("t6_opsize", 16'(pfx_opsize), 16'h0);
        consumeBundle();

        // Sixteen lock prefixes: counter saturates at 15
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 8'hF0);
        end
        applyStimulus(1'b1, 8'h90);
        checkOutput("t7_count_sat", 16'(pfx_count), 16'hF);
        checkOutput("t7_lock", 16'(pfx_lock), 16'h1);
        checkOutput("t7_err", 16'(pfx_err), 16'h1);
        checkOutput("t7_opcode", opcode, 16'h0090);
        consumeBundle();

        // Asynchronous reset in the middle of 65 0F: everything dropped
        applyStimulus(1'b1, 8'h65);
        applyStimulus(1'b1, 8'h0F);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        checkOutput("t8_rst_seg_vld", 16'(seg_ovr_vld), 16'h0);
        checkOutput("t8_rst_count", 16'(pfx_count), 16'h0);
        checkOutput("t8_rst_opcode", opcode, 16'h0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b1, 8'h40);
        checkOutput("t8_out_valid", 16'(out_valid), 16'h1);
        checkOutput("t8_opcode", opcode, 16'h0040);
        checkOutput("t8_seg_vld", 16'(seg_ovr_vld), 16'h0);
        consumeBundle();

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
